// File: rtl/seletor_pkg.sv
// Shared definitions for the quadrant selector: FSM state encoding,
// the "no quadrant" code and a one-hot test helper.
package seletor_pkg;

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        ESTABILIZA    = 2'd1,
        REGISTRA      = 2'd2,
        ESPERA_SOLTAR = 2'd3
    } estado_t;

    localparam logic [8:0] QUAD_NENHUM = 9'b0;

    // True only when exactly one bit of v is set.
    function automatic logic eh_one_hot(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

endpackage

// File: rtl/seletor_quadrante_sincronizador.sv
// Two-flop synchroniser for a bus of independent asynchronous inputs.
// Each bit is synchronised on its own; no cross-bit coherence is implied.
module sincronizador #(
    parameter int W = 9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/seletor_quadrante.sv
// Debounced single-button quadrant selector producing a registered one-hot code.
// Define SELETOR_OCUPADO_CHECK_EN to reject presses on occupied quadrants.
module seletor_quadrante
    import seletor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] botoes,
    input  logic       habilita,
    input  logic [8:0] ocupado,
    input  logic       limpar,
    output logic [8:0] quadrante,
    output logic       jogada_valida,
    output logic       jogada_invalida
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The counter is compared before incrementing, so the last count is D-1.
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] UM     = CNT_W'(1);

    logic [8:0]       sync;
    estado_t          estado, estado_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [8:0]       cand, cand_nxt;
    logic             livre;
    logic             valida_nxt, invalida_nxt;
    logic [8:0]       quadrante_nxt;

    sincronizador #(.W(9)) u_sinc (
        .clock (clock),
        .reset (reset),
        .d     (botoes),
        .q     (sync)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
            cnt    <= '0;
            cand   <= QUAD_NENHUM;
        end else begin
            estado <= estado_nxt;
            cnt    <= cnt_nxt;
            cand   <= cand_nxt;
        end
    end

    always_comb begin
        estado_nxt = estado;
        cnt_nxt    = cnt;
        cand_nxt   = cand;
        case (estado)
            OCIOSO: begin
                if (sync != QUAD_NENHUM) begin
                    if (habilita && eh_one_hot(sync)) begin
                        cand_nxt   = sync;
                        cnt_nxt    = UM;
                        estado_nxt = ESTABILIZA;
                    end else begin
                        cnt_nxt    = '0;
                        estado_nxt = ESPERA_SOLTAR;
                    end
                end
            end
            ESTABILIZA: begin
                if (sync != cand) begin
                    cnt_nxt    = '0;
                    estado_nxt = OCIOSO;
                end else if (!habilita) begin
                    cnt_nxt    = '0;
                    estado_nxt = ESPERA_SOLTAR;
                end else if (cnt >= ULTIMO) begin
                    cnt_nxt    = '0;
                    estado_nxt = REGISTRA;
                end else begin
                    cnt_nxt = cnt + UM;
                end
            end
            REGISTRA: begin
                cnt_nxt    = '0;
                estado_nxt = ESPERA_SOLTAR;
            end
            ESPERA_SOLTAR: begin
                // Any activity restarts the release window, so a held button is never re-accepted.
                if (sync != QUAD_NENHUM) begin
                    cnt_nxt = '0;
                end else if (cnt >= ULTIMO) begin
                    cnt_nxt    = '0;
                    estado_nxt = OCIOSO;
                end else begin
                    cnt_nxt = cnt + UM;
                end
            end
            default: begin
                cnt_nxt    = '0;
                estado_nxt = OCIOSO;
            end
        endcase
    end

`ifdef SELETOR_OCUPADO_CHECK_EN
    assign livre = ((cand & ocupado) == QUAD_NENHUM);
`else
    logic ocupado_unused;
    assign ocupado_unused = ^ocupado;
    assign livre          = 1'b1;
`endif

    always_comb begin
        valida_nxt    = 1'b0;
        invalida_nxt  = 1'b0;
        quadrante_nxt = quadrante;
        if (estado == REGISTRA) begin
            valida_nxt   = livre;
            invalida_nxt = !livre;
        end
        if (valida_nxt)
            quadrante_nxt = cand;
        // Clearing overrides a same-cycle acceptance; the pulse is still reported.
        if (limpar)
            quadrante_nxt = QUAD_NENHUM;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quadrante       <= QUAD_NENHUM;
            jogada_valida   <= 1'b0;
            jogada_invalida <= 1'b0;
        end else begin
            quadrante       <= quadrante_nxt;
            jogada_valida   <= valida_nxt;
            jogada_invalida <= invalida_nxt;
        end
    end

endmodule

// File: doc/seletor_quadrante.md
# seletor_quadrante

Captures the player's quadrant choice from nine raw push-buttons and delivers it as a registered 9-bit one-hot code to the quadrant display decoder (digits 1–9, "-" for no choice) and to the game controller. Synchronises and debounces the buttons, accepts only clean single-button presses while a move is allowed, and optionally rejects presses on occupied quadrants. Sits between the board I/O pins and the display/game-control datapath.

## Interface
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a press or a release (≥1; 1 ms at 50 MHz)
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- botoes  in  9  raw buttons, bit i = quadrant i+1, active-high, asynchronous
- habilita  in  1  move allowed (from game controller)
- ocupado  in  9  board occupancy mask, bit i = quadrant i+1 taken
- limpar  in  1  synchronous clear of the held quadrant
- quadrante  out  9  one-hot selected quadrant, 0 = none; drives the display decoder
- jogada_valida  out  1  one-cycle pulse: new quadrant accepted
- jogada_invalida  out  1  one-cycle pulse: press rejected (occupied)

## Operation
- botoes passes a 2-FF synchroniser → sync[8:0]. Only sync is used downstream.
- Stability counter cnt, width $clog2(DEBOUNCE_CYCLES+1); candidate register cand[8:0].
- FSM states: OCIOSO, ESTABILIZA, REGISTRA, ESPERA_SOLTAR.
- OCIOSO: sync==0 → stay. sync nonzero and habilita=0 → ESPERA_SOLTAR. sync exactly one-hot and habilita=1 → cand=sync, cnt=1, ESTABILIZA. sync multi-hot → ESPERA_SOLTAR.
- ESTABILIZA: sync≠cand → OCIOSO (restart). habilita=0 → ESPERA_SOLTAR. Else cnt increments; when cnt reaches DEBOUNCE_CYCLES → REGISTRA.
- REGISTRA (one cycle): if cand&ocupado==0 (or check compiled out): quadrante←cand, jogada_valida=1. Else jogada_invalida=1, quadrante unchanged. Always → ESPERA_SOLTAR.
- ESPERA_SOLTAR: counts consecutive cycles with sync==0; any nonzero sync resets cnt to 0; after DEBOUNCE_CYCLES zero cycles → OCIOSO. A held button is never accepted twice.
- limpar=1: quadrante←0 on that edge; wins over a same-cycle REGISTRA update (pulse still emitted). FSM unaffected.
- quadrante is always 0 or exactly one-hot.

## Timing
- Reset values: quadrante=0, jogada_valida=0, jogada_invalida=0, state=OCIOSO, cnt=0, cand=0, synchroniser=0.
- Latency: raw press stable from edge t → sync valid at t+2 → ESTABILIZA at t+3 → REGISTRA entered at t+2+DEBOUNCE_CYCLES → quadrante and pulse registered at t+3+DEBOUNCE_CYCLES.
- Pulses are registered outputs, high exactly one cycle.
- Reset mid-operation: all state returns to reset values immediately; a button held across reset release is treated as a new press.
- habilita sampled each cycle; only its level in OCIOSO/ESTABILIZA matters.

## Configuration
- SELETOR_OCUPADO_CHECK_EN defined: occupancy check active as in REGISTRA; occupied press → jogada_invalida, quadrante held.
- Undefined: ocupado is ignored (port kept), every debounced press is accepted, jogada_invalida is tied 0.

## Structure
- Package seletor_pkg: state encoding (OCIOSO=0, ESTABILIZA=1, REGISTRA=2, ESPERA_SOLTAR=3), QUAD_NENHUM = 9'b0, one-hot check function.
- Sub-module: sincronizador (parameterised-width 2-FF synchroniser, async active-low reset).

## Test plan
(bench DEBOUNCE_CYCLES=4)
- Reset, botoes=0 → quadrante=0, both pulses 0 for 20 cycles.
- habilita=1, botoes=9'b000010000 held 20 cycles → jogada_valida pulse at t+7, quadrante=9'b000010000; no second pulse while held.
- Bounce: bit 2 toggled every 2 cycles for 12 cycles, then held → single acceptance, quadrante=9'b000000100, only after bouncing stops.
- Two buttons (9'b000000011) held → no pulse, quadrante unchanged; release and press bit 8 → quadrante=9'b100000000.
- ocupado=9'b000001000, press bit 3 → with SELETOR_OCUPADO_CHECK_EN: jogada_invalida pulse, quadrante unchanged; without: jogada_valida, quadrante=9'b000001000.
- habilita=0 during press then raised while held → no acceptance until release and new press; limpar in REGISTRA cycle → pulse seen, quadrante=0.
